// File: rtl/fp_minmax_reduce.sv
// Streaming IEEE-754 min/max reduction over masked multi-beat packets, reporting winner index and invalid flag.
// Latency: result valid the cycle after the in_last beat is accepted; one packet per (beats+1) cycles.
// Backpressure: in_ready_o drops while a result is held; the result waits until out_ready_i handshakes it.
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   in_valid_i / in_ready_o            input beat handshake
//   in_data_i, in_mask_i, in_last_i    LANES operands (lane i at [i*W +: W]), lane enables, end of packet
//   op_max_i                           1 = MAX, 0 = MIN, taken from the first beat of a packet
//   out_valid_o / out_ready_i          result handshake
//   out_data_o, out_idx_o              reduced value and index (beat*LANES+lane) of the winner
//   out_nv_o, out_empty_o              sNaN seen among unmasked lanes; no unmasked non-NaN element
module fp_minmax_reduce #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int LANES = 4,
    parameter int IDX_W = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_data_i,
    input  logic [LANES-1:0]                 in_mask_i,
    input  logic                             in_last_i,
    input  logic                             op_max_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [(1+EXP_W+MAN_W)-1:0]       out_data_o,
    output logic [IDX_W-1:0]                 out_idx_o,
    output logic                             out_nv_o,
    output logic                             out_empty_o
);

    localparam int W = 1 + EXP_W + MAN_W;
    // Tree width rounded up to a power of two; padding lanes behave as masked.
    localparam int P = (LANES <= 1) ? 1 : (1 << $clog2(LANES));
    localparam logic [W-1:0] CNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0]     val;
        logic [IDX_W-1:0] idx;
    } elem_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Floating-point helpers
    // ------------------------------------------------------------------
    function automatic logic is_nan(input logic [W-1:0] v);
        return (&v[W-2:MAN_W]) && (|v[MAN_W-1:0]);
    endfunction

    // Quiet bit clear and remaining fraction non-zero.
    function automatic logic is_snan(input logic [W-1:0] v);
        return (&v[W-2:MAN_W]) && !v[MAN_W-1] && (|v[MAN_W-2:0]);
    endfunction

    // Map the encoding onto an unsigned key whose order is the numeric
    // order: negatives are bit-inverted, positives get the top bit set.
    // This places -0 just below +0 and keeps infinities at the ends.
    function automatic logic [W-1:0] ord_key(input logic [W-1:0] v);
        return v[W-1] ? ~v : {1'b1, v[W-2:0]};
    endfunction

    // Two-element combine. Callers always pass the lower-index element as
    // 'a', so keeping 'a' on equal keys gives the lower-index tie rule.
    function automatic elem_t pick(input elem_t a, input elem_t b, input logic mx);
        logic         a_nan;
        logic         b_nan;
        logic         b_wins;
        logic [W-1:0] ka;
        logic [W-1:0] kb;
        elem_t        r;
        a_nan  = is_nan(a.val);
        b_nan  = is_nan(b.val);
        ka     = ord_key(a.val);
        kb     = ord_key(b.val);
        b_wins = mx ? (kb > ka) : (kb < ka);
        r      = a;
        if (a_nan && b_nan) begin
            r.val = CNAN;
            r.idx = a.idx;
        end else if (a_nan) begin
            r = b;
        end else if (b_nan) begin
            r = a;
        end else if (b_wins) begin
            r = b;
        end
        return r;
    endfunction

    // Heap-ordered reduction tree over one beat: leaves at [P..2P-1],
    // node k combines children 2k (lower lanes) and 2k+1.
    function automatic elem_t reduce_beat(input logic [P*W-1:0]  d,
                                          input logic [P-1:0]    m,
                                          input logic [IDX_W-1:0] base,
                                          input logic            mx);
        elem_t node [1:2*P-1];
        for (int i = 0; i < P; i++) begin
            node[P+i].idx = base + IDX_W'(i);
            node[P+i].val = m[i] ? d[i*W +: W] : CNAN;
        end
        for (int k = P - 1; k >= 1; k--) begin
            node[k] = pick(node[2*k], node[2*k+1], mx);
        end
        return node[1];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    elem_t            acc_q, acc_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             nv_q, nv_d;
    logic             op_q, op_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_nv_q, out_nv_d;
    logic             out_empty_q, out_empty_d;

    logic             accept;
    logic             release_out;
    logic             op_eff;
    logic [P*W-1:0]   data_pad;
    logic [P-1:0]     mask_pad;
    logic [IDX_W-1:0] beat_base;
    elem_t            beat_res;
    elem_t            fold;
    logic             beat_snan;

    assign accept      = in_valid_i && in_ready_o;
    assign release_out = out_valid_o && out_ready_i;

    // The first beat of a packet uses the live op input; later beats use
    // the value captured on that first beat.
    assign op_eff    = (state_q == S_IDLE) ? op_max_i : op_q;
    assign data_pad  = (P*W)'(in_data_i);
    assign mask_pad  = P'(in_mask_i);
    assign beat_base = IDX_W'(cnt_q * LANES);
    assign beat_res  = reduce_beat(data_pad, mask_pad, beat_base, op_eff);
    // Accumulator holds earlier beats, i.e. lower indices, so it goes left.
    assign fold      = pick(acc_q, beat_res, op_eff);

    always_comb begin
        beat_snan = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_mask_i[i] && is_snan(in_data_i[i*W +: W])) begin
                beat_snan = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_last_i ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (accept && in_last_i) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_o  = 1'b1;
            S_ACC:   in_ready_o  = 1'b1;
            S_OUT:   out_valid_o = 1'b1;
            default: in_ready_o  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        nv_d        = nv_q;
        op_d        = op_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_nv_d    = out_nv_q;
        out_empty_d = out_empty_q;

        if (accept) begin
            acc_d = fold;
            nv_d  = nv_q | beat_snan;
            cnt_d = cnt_q + 1'b1;
            if (state_q == S_IDLE) begin
                op_d = op_max_i;
            end
            if (in_last_i) begin
                out_data_d  = fold.val;
                out_idx_d   = fold.idx;
                out_nv_d    = nv_q | beat_snan;
                // Only NaN can survive the fold when nothing numeric was seen.
                out_empty_d = is_nan(fold.val);
            end
        end

        if (release_out) begin
            acc_d.val = CNAN;
            acc_d.idx = '0;
            cnt_d     = '0;
            nv_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q.val   <= CNAN;
            acc_q.idx   <= '0;
            cnt_q       <= '0;
            nv_q        <= 1'b0;
            op_q        <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_nv_q    <= 1'b0;
            out_empty_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            nv_q        <= nv_d;
            op_q        <= op_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_nv_q    <= out_nv_d;
            out_empty_q <= out_empty_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_nv_o    = out_nv_q;
    assign out_empty_o = out_empty_q;

endmodule
